// File: rtl/fifo_top_pkg.sv
// Shared constants and types for the fifo_top byte FIFO.
// Optional status ports are enabled with the FIFO_TOP_STATUS_EN macro.
package fifo_top_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 16;
  localparam int ADDR_WIDTH = 4;

  typedef logic [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/fifo_top_if.sv
// Producer/consumer handshake bundle for fifo_top_blk.
// Defining FIFO_TOP_STATUS_EN adds the full/empty/count status signals.
interface fifo_top_if
  import fifo_top_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_top_pkg::DATA_WIDTH
`ifdef FIFO_TOP_STATUS_EN
  , parameter int ADDR_WIDTH = fifo_top_pkg::ADDR_WIDTH
`endif
) ();

  logic                  write_signal;
  logic                  read_signal;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
`ifdef FIFO_TOP_STATUS_EN
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
`endif

  // Producer/consumer side: drives requests and write data
  modport master (
    output write_signal,
    output read_signal,
    output data_in,
    input  data_out
`ifdef FIFO_TOP_STATUS_EN
    , input full
    , input empty
    , input count
`endif
  );

  // FIFO side
  modport slave (
    input  write_signal,
    input  read_signal,
    input  data_in,
    output data_out
`ifdef FIFO_TOP_STATUS_EN
    , output full
    , output empty
    , output count
`endif
  );

endinterface

// File: rtl/fifo_top_mem.sv
// Storage array for the FIFO: synchronous write port and a registered
// read port. The array itself is never reset; only the read register is.
module fifo_top_mem
  import fifo_top_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_top_pkg::DATA_WIDTH,
  parameter int DEPTH      = fifo_top_pkg::DEPTH,
  parameter int ADDR_WIDTH = fifo_top_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: store the incoming word at the write address
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: capture the addressed word; hold otherwise so underflow keeps the last value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_top_blk.sv
// Single-clock byte FIFO with registered read data. Overflow writes and
// underflow reads are dropped without any state change.
// Optional macro FIFO_TOP_STATUS_EN exposes full/empty/count on the bus.
module fifo_top_blk
  import fifo_top_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_top_pkg::DATA_WIDTH,
  parameter int DEPTH      = fifo_top_pkg::DEPTH,
  parameter int ADDR_WIDTH = fifo_top_pkg::ADDR_WIDTH
) (
  input  logic      clk,
  input  logic      rst_n,
  fifo_top_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] COUNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  wr_en;
  logic                  rd_en;

  // Flags come from registered occupancy, so a same-cycle read never frees
  // room for a write when full, and a same-cycle write never feeds a read when empty.
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign wr_en = bus.write_signal & ~full;
  assign rd_en = bus.read_signal & ~empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  fifo_top_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (bus.data_in),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (bus.data_out)
  );

`ifdef FIFO_TOP_STATUS_EN
  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.count = count;
`endif

endmodule

// File: tb/tb_fifo_top_blk.sv
// Directed plus randomized bench for fifo_top_blk, checked against a
// queue-based reference model of the FIFO behaviour.
module tb_fifo_top_blk;
  import fifo_top_pkg::*;

  logic clk;
  logic rst_n;

  fifo_top_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

  fifo_top_blk #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: queue of stored bytes plus the last value read out
  data_t q[$];
  data_t exp_out;
  int    passed;
  int    total;

  task automatic check_val(input string tag, input data_t got, input data_t exp);
    total++;
    assert (got === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: data_out=%02h expected %02h", tag, got, exp);
    end
  endtask

`ifdef FIFO_TOP_STATUS_EN
  task automatic check_status(input string tag);
    int n;
    n = q.size();
    total++;
    assert ((bus.count === (ADDR_WIDTH + 1)'(n)) && (bus.full === (n == DEPTH)) &&
            (bus.empty === (n == 0))) begin
      passed++;
    end else begin
      $error("FAIL %s_status: count=%0d full=%b empty=%b expected count=%0d", tag,
             bus.count, bus.full, bus.empty, n);
    end
  endtask
`endif

  // One clock cycle: drive at the falling edge, update the model at the
  // rising edge, compare shortly after it.
  task automatic step(input logic w, input logic r, input data_t d, input string tag);
    bit wr_ok;
    bit rd_ok;
    @(negedge clk);
    bus.write_signal = w;
    bus.read_signal  = r;
    bus.data_in      = d;
    @(posedge clk);
    wr_ok = w && (q.size() < DEPTH);
    rd_ok = r && (q.size() > 0);
    if (rd_ok) exp_out = q.pop_front();
    if (wr_ok) q.push_back(d);
    #1;
    $display("%s: w=%b r=%b din=%02h -> data_out=%02h (model %02h, depth %0d)",
             tag, w, r, d, bus.data_out, exp_out, q.size());
    check_val(tag, bus.data_out, exp_out);
`ifdef FIFO_TOP_STATUS_EN
    check_status(tag);
`endif
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic pulse_reset(input string tag);
    #2;
    rst_n = 1'b1;
    q.delete();
    exp_out = '0;
    #1;
    $display("%s: reset asserted -> data_out=%02h", tag, bus.data_out);
    check_val(tag, bus.data_out, exp_out);
`ifdef FIFO_TOP_STATUS_EN
    check_status(tag);
`endif
    rst_n = 1'b0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    exp_out = '0;
    rst_n = 1'b0;
    bus.write_signal = 1'b0;
    bus.read_signal  = 1'b0;
    bus.data_in      = '0;

    // Reset pulse with no clock edge inside it
    #1;
    rst_n = 1'b1;
    #1;
    $display("reset: data_out=%02h", bus.data_out);
    check_val("reset", bus.data_out, 8'h00);
`ifdef FIFO_TOP_STATUS_EN
    check_status("reset");
`endif
    rst_n = 1'b0;

    // Underflow straight after reset
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hEE, "underflow");

    // Fill then drain, data changing every two writes
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, data_t'(i / 2), "fill");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00, "drain");

    // Overflow: 20 writes into an empty FIFO, then 20 reads
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, data_t'(i), "ovf_wr");
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'h00, "ovf_rd");

    // Simultaneous read/write at occupancy 5 with pointers starting near the wrap
    pulse_reset("sim_rst");
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, data_t'(8'h30 + i), "sim_pre_wr");
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'h00, "sim_pre_rd");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, data_t'(8'h10 + i), "sim_load");
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, data_t'(8'hA0 + i), "sim_rw");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'h00, "sim_drain");

    // Simultaneous read/write while full: write must be rejected
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, data_t'(8'h60 + i), "full_load");
    step(1'b1, 1'b1, 8'hFF, "full_rw");
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, "full_drain");

    // Simultaneous read/write while empty: no fall-through
    step(1'b1, 1'b1, 8'h77, "empty_rw");
    step(1'b0, 1'b1, 8'h00, "empty_rw_rd");

    // Mid-operation reset
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, data_t'(8'hC0 + i), "mid_load");
    step(1'b0, 1'b1, 8'h00, "mid_rd");
    pulse_reset("mid_rst");
    step(1'b0, 1'b1, 8'h00, "mid_rd_empty");
    step(1'b1, 1'b0, 8'h55, "mid_wr55");
    step(1'b0, 1'b1, 8'h00, "mid_rd55");

    // Randomized traffic, alternating write-heavy and read-heavy phases
    for (int i = 0; i < 400; i++) begin
      int wprob;
      bit w;
      bit r;
      wprob = ((i / 50) % 2 == 0) ? 75 : 25;
      w = ($urandom_range(0, 99) < wprob);
      r = ($urandom_range(0, 99) < (100 - wprob));
      step(w, r, data_t'($urandom_range(0, 255)), "rand");
    end

    @(negedge clk);
    bus.write_signal = 1'b0;
    bus.read_signal  = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("FAIL timeout: run did not complete, required completion before 200000");
    $fatal(1, "timeout");
  end

endmodule
